// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - sizing helpers for the shared-ALU arbiter
package alu_arbiter_pkg;

    localparam int N_REQ_MAX = 8;

    // Requester ID tag width: ceil(log2(n)), never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared RISC-V word width, ALU operator codes and operator-support helper
package riscv_defines;

    localparam int WORD_WIDTH   = 32;
    localparam int ALU_OP_WIDTH = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 7'b0101111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 7'b0101110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 7'b0010101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 7'b0100100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 7'b0100101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 7'b0100111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 7'b0000010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 7'b0000011;

    function automatic logic alu_op_supported(input logic [ALU_OP_WIDTH-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
            ALU_SRA, ALU_SRL, ALU_SLL, ALU_SLT, ALU_SLTU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between requesters, consumer and the shared-ALU arbiter
interface alu_arbiter_if
    import riscv_defines::*;
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = id_width(N_REQ)
);

    logic [N_REQ-1:0]              req_valid_i;
    logic [N_REQ-1:0]              req_ready_o;
    logic [N_REQ*WORD_WIDTH-1:0]   req_operand_a_i;
    logic [N_REQ*WORD_WIDTH-1:0]   req_operand_b_i;
    logic [N_REQ*ALU_OP_WIDTH-1:0] req_operator_i;
    logic                          rsp_valid_o;
    logic                          rsp_ready_i;
    logic [WORD_WIDTH-1:0]         rsp_result_o;
    logic [ID_W-1:0]               rsp_id_o;
    logic                          rsp_err_o;

    modport master (
        output req_valid_i, req_operand_a_i, req_operand_b_i, req_operator_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_operand_a_i, req_operand_b_i, req_operator_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o, rsp_err_o
    );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU; unsupported operators yield zero
module alu
    import riscv_defines::*;
(
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [WORD_WIDTH-1:0]   operand_a_i,
    input  logic [WORD_WIDTH-1:0]   operand_b_i,
    output logic [WORD_WIDTH-1:0]   result_o
);

    logic [4:0] shamt;
    assign shamt = operand_b_i[4:0];

    always_comb begin
        result_o = '0;
        case (operator_i)
            ALU_ADD:  result_o = operand_a_i + operand_b_i;
            ALU_SUB:  result_o = operand_a_i - operand_b_i;
            ALU_AND:  result_o = operand_a_i & operand_b_i;
            ALU_OR:   result_o = operand_a_i | operand_b_i;
            ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
            ALU_SLL:  result_o = operand_a_i << shamt;
            ALU_SRL:  result_o = operand_a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(operand_a_i) >>> shamt);
            ALU_SLT:  result_o = {{(WORD_WIDTH-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
            ALU_SLTU: result_o = {{(WORD_WIDTH-1){1'b0}}, operand_a_i < operand_b_i};
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// rtl/alu_arbiter_rr_arbiter.sv - round-robin grant logic (priority encoder with ALU_ARB_FIXED_PRIO_EN)
module alu_rr_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx
);

    logic [ID_W-1:0] start;
    logic [ID_W-1:0] cand;
    logic            found;

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^{clk, rst, advance};
    assign start     = '0;
`else
    logic [ID_W-1:0] last_grant;

    // Reset to the top index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= ID_W'(N_REQ - 1);
        end else if (advance) begin
            last_grant <= gnt_idx;
        end
    end

    assign start = (int'(last_grant) == N_REQ - 1) ? '0 : last_grant + ID_W'(1);
`endif

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = ID_W'((int'(start) + off) % N_REQ);
            if (enable && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU among N_REQ requesters with a tagged one-slot response register
// Optional: ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_arbiter
    import riscv_defines::*;
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]        gnt;
    logic [ID_W-1:0]         gnt_idx;
    logic                    can_accept;
    logic                    enable;
    logic                    fire;
    logic [WORD_WIDTH-1:0]   sel_a;
    logic [WORD_WIDTH-1:0]   sel_b;
    logic [ALU_OP_WIDTH-1:0] sel_op;
    logic [WORD_WIDTH-1:0]   alu_result;

    logic                    rsp_valid_q;
    logic [WORD_WIDTH-1:0]   rsp_result_q;
    logic [ID_W-1:0]         rsp_id_q;
    logic                    rsp_err_q;

    // Capacity only depends on the response register and rsp_ready_i, never on req_valid_i.
    assign can_accept = !rsp_valid_q || bus.rsp_ready_i;
    assign enable     = can_accept && !rst;
    assign fire       = |gnt;

    alu_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid_i),
        .enable  (enable),
        .advance (fire),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_a  = bus.req_operand_a_i[k*WORD_WIDTH +: WORD_WIDTH];
                sel_b  = bus.req_operand_b_i[k*WORD_WIDTH +: WORD_WIDTH];
                sel_op = bus.req_operator_i[k*ALU_OP_WIDTH +: ALU_OP_WIDTH];
            end
        end
    end

    alu u_alu (
        .operator_i  (sel_op),
        .operand_a_i (sel_a),
        .operand_b_i (sel_b),
        .result_o    (alu_result)
    );

    // A new accept in the retire cycle overwrites the slot, keeping rsp_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else if (fire) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_result;
            rsp_id_q     <= gnt_idx;
            rsp_err_q    <= !alu_op_supported(sel_op);
        end else if (bus.rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.req_ready_o  = gnt;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_result_o = rsp_result_q;
    assign bus.rsp_id_o     = rsp_id_q;
    assign bus.rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
    import riscv_defines::*;

    localparam int N = 2;
    localparam int W = WORD_WIDTH;
    localparam int OW = ALU_OP_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.N_REQ(N)) bus ();

    alu_arbiter #(.N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    bit          m_valid;
    logic [31:0] m_result;
    int          m_id;
    bit          m_err;
    int          rr_last;
    int          last_g;
    logic [N-1:0] acc_mask;

    logic [OW-1:0] ops [10];
    int fair_exp [4];
    logic [31:0] op_exp [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [OW-1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output bit err);
        int sh;
        sh  = int'(b[4:0]);
        err = 1'b0;
        if      (op == ALU_ADD)  return a + b;
        else if (op == ALU_SUB)  return a - b;
        else if (op == ALU_AND)  return a & b;
        else if (op == ALU_OR)   return a | b;
        else if (op == ALU_XOR)  return a ^ b;
        else if (op == ALU_SLL)  return a << sh;
        else if (op == ALU_SRL)  return a >> sh;
        else if (op == ALU_SRA)  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        else if (op == ALU_SLT)  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        else if (op == ALU_SLTU) return (a < b) ? 32'd1 : 32'd0;
        err = 1'b1;
        return 32'h0;
    endfunction

    function automatic int pick(input logic [N-1:0] v);
        int start;
`ifdef ALU_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = (rr_last + 1) % N;
`endif
        for (int off = 0; off < N; off++) begin
            if (v[(start + off) % N]) return (start + off) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_result = '0;
        m_id     = 0;
        m_err    = 1'b0;
        rr_last  = N - 1;
    endtask

    task automatic step();
        logic [N-1:0] exp_ready;
        int g;
        bit can;
        bit e;
        acc_mask = '0;
        @(negedge clk);
        can = !m_valid || bus.rsp_ready_i;
        g = (rst || !can) ? -1 : pick(bus.req_valid_i);
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        check("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
        last_g = g;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (g >= 0) begin
            m_result = ref_alu(bus.req_operator_i[g*OW +: OW], bus.req_operand_a_i[g*W +: W],
                               bus.req_operand_b_i[g*W +: W], e);
            m_err       = e;
            m_id        = g;
            m_valid     = 1'b1;
            rr_last     = g;
            acc_mask[g] = 1'b1;
        end else if (bus.rsp_ready_i) begin
            m_valid = 1'b0;
        end
        #1;
        check("rsp_valid",  32'(bus.rsp_valid_o),  32'(m_valid));
        check("rsp_result", bus.rsp_result_o,      m_result);
        check("rsp_id",     32'(bus.rsp_id_o),     32'(m_id));
        check("rsp_err",    32'(bus.rsp_err_o),    32'(m_err));
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic [OW-1:0] op);
        bus.req_operand_a_i[k*W +: W] = a;
        bus.req_operand_b_i[k*W +: W] = b;
        bus.req_operator_i[k*OW +: OW] = op;
    endtask

    initial begin
        ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU};
`ifdef ALU_ARB_FIXED_PRIO_EN
        fair_exp = '{0, 0, 0, 0};
`else
        fair_exp = '{0, 1, 0, 1};
`endif
        op_exp = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0001, 32'h0000_0000};
        model_reset();

        rst = 1'b1;
        bus.req_valid_i     = '0;
        bus.req_operand_a_i = '0;
        bus.req_operand_b_i = '0;
        bus.req_operator_i  = '0;
        bus.rsp_ready_i     = 1'b0;
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;

        // Single request, SUB on requester 0
        set_req(0, 32'h5, 32'h3, ALU_SUB);
        bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 2'b01;
        step();
        check("single_gnt", 32'(last_g), 32'd0);
        check("single_result", bus.rsp_result_o, 32'h2);
        check("single_id", 32'(bus.rsp_id_o), 32'd0);
        check("single_valid", 32'(bus.rsp_valid_o), 32'd1);
        bus.req_valid_i = '0;
        step();

        // Fairness from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        set_req(0, 32'd10, 32'd1, ALU_ADD);
        set_req(1, 32'd20, 32'd2, ALU_ADD);
        bus.req_valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fair_gnt", 32'(last_g), 32'(fair_exp[i]));
            check("fair_rsp_id", 32'(bus.rsp_id_o), 32'(fair_exp[i]));
        end

        // Backpressure: pending response held for three cycles
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ready", 32'(bus.req_ready_o), 32'd0);
        end
        bus.rsp_ready_i = 1'b1;
        step();
        check("bp_accept", 32'(last_g >= 0), 32'd1);
        check("bp_valid", 32'(bus.rsp_valid_o), 32'd1);

        // Shift / compare operators on requester 0
        rst = 1'b1; step(); rst = 1'b0;
        bus.req_valid_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 32'h8000_0000, 32'h4, ops[7 - (i == 1 ? 1 : 0) + (i >= 2 ? i - 1 : 0)]);
            step();
            check("op_result", bus.rsp_result_o, op_exp[i]);
        end

        // Unsupported operator on requester 1
        bus.req_valid_i = 2'b10;
        set_req(1, 32'h1234_5678, 32'h1, 7'h7F);
        step();
        check("unsup_err", 32'(bus.rsp_err_o), 32'd1);
        check("unsup_result", bus.rsp_result_o, 32'h0);
        check("unsup_id", 32'(bus.rsp_id_o), 32'd1);

        // Reset with a pending response and both requesters valid
        bus.req_valid_i = 2'b11;
        set_req(0, 32'd7, 32'd8, ALU_OR);
        set_req(1, 32'd9, 32'd3, ALU_XOR);
        bus.rsp_ready_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
        rst = 1'b0;
        step();
        check("rst_first_gnt", 32'(last_g), 32'd0);

        // Randomized traffic; a request holds its payload until accepted
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!bus.req_valid_i[k] || acc_mask[k]) begin
                    bus.req_valid_i[k] = 1'($urandom_range(0, 2) != 0);
                    set_req(k, $urandom(), ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 40)),
                            ($urandom_range(0, 9) == 0) ? OW'($urandom()) : ops[$urandom_range(0, 9)]);
                end
            end
            bus.rsp_ready_i = 1'($urandom_range(0, 3) != 0);
            rst = 1'($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
